// File: rtl/sorter_frame_loader_if.sv
// Stream-in / frame-out bundle for the sorter frame loader.
// The master side feeds elements; the slave side is the loader.
interface sorter_frame_loader_if #(
  parameter int DATAWIDTH = 8
);
  logic                 s_valid_i;
  logic                 s_ready_o;
  logic [DATAWIDTH-1:0] s_data_i;
  logic                 s_last_i;
  logic                 sign_ctrl_i;
  logic [DATAWIDTH-1:0] x_o [32];
  logic [5:0]           data_length_o;
  logic                 sign_ctrl_o;
  logic                 launch_o;
  logic                 split_o;
  logic [15:0]          frame_cnt_o;

  modport master (
    output s_valid_i, s_data_i, s_last_i, sign_ctrl_i,
    input  s_ready_o, x_o, data_length_o, sign_ctrl_o,
    input  launch_o, split_o, frame_cnt_o
  );

  modport slave (
    input  s_valid_i, s_data_i, s_last_i, sign_ctrl_i,
    output s_ready_o, x_o, data_length_o, sign_ctrl_o,
    output launch_o, split_o, frame_cnt_o
  );
endinterface

// File: rtl/sorter_frame_loader.sv
// Collects a serial element stream into a 32-deep frame buffer and
// presents each frame to the sorter for exactly one launch cycle.
module sorter_frame_loader #(
  parameter int DATAWIDTH      = 8,
  parameter int MAX_DATALENGTH = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  sorter_frame_loader_if.slave bus
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    FILL   = 2'd1,
    LAUNCH = 2'd2
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(MAX_DATALENGTH - 1);

  state_t               state_q, state_d;
  logic [4:0]           count_q;
  logic [DATAWIDTH-1:0] x_q [MAX_DATALENGTH];
  logic [5:0]           len_q;
  logic                 sign_q;
  logic                 launch_q;
  logic                 split_q;
  logic [15:0]          fcnt_q;
  logic                 ready;
  logic                 beat;
  logic                 done;

  assign beat = bus.s_valid_i & ready;
  // Frame closes on an explicit last or when the buffer fills up.
  assign done = beat & (bus.s_last_i | (count_q == LAST_IDX));

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= INIT;
    else       state_q <= state_d;
  end

  // Next-state logic: one bubble cycle after every frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    state_d = FILL;
      FILL:    if (done) state_d = LAUNCH;
      LAUNCH:  state_d = FILL;
      default: state_d = INIT;
    endcase
  end

  // Output decode: only FILL accepts elements.
  always_comb begin
    ready = 1'b0;
    if (state_q == FILL) ready = 1'b1;
  end

  // Frame buffer, length counter and launch outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      len_q    <= '0;
      sign_q   <= 1'b0;
      launch_q <= 1'b0;
      split_q  <= 1'b0;
      fcnt_q   <= '0;
      for (int i = 0; i < MAX_DATALENGTH; i++) x_q[i] <= '0;
    end else begin
      if (state_q == LAUNCH) begin
        len_q    <= '0;
        launch_q <= 1'b0;
        split_q  <= 1'b0;
      end
      if (beat) begin
        x_q[count_q] <= bus.s_data_i;
        count_q      <= count_q + 5'd1;
        if (count_q == 5'd0) sign_q <= bus.sign_ctrl_i;
      end
      if (done) begin
        len_q    <= 6'(count_q) + 6'd1;
        launch_q <= 1'b1;
        split_q  <= ~bus.s_last_i;
        fcnt_q   <= fcnt_q + 16'd1;
        count_q  <= '0;
      end
    end
  end

  assign bus.s_ready_o     = ready;
  assign bus.x_o           = x_q;
  assign bus.data_length_o = len_q;
  assign bus.sign_ctrl_o   = sign_q;
  assign bus.launch_o      = launch_q;
  assign bus.split_o       = split_q;
  assign bus.frame_cnt_o   = fcnt_q;

endmodule

// File: tb/tb_sorter_frame_loader.sv
// Bench for sorter_frame_loader: directed frames plus random
// streams, checked against a frame-level queue model.
module tb_sorter_frame_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  sorter_frame_loader_if #(.DATAWIDTH(8)) bus ();

  sorter_frame_loader #(
    .DATAWIDTH(8),
    .MAX_DATALENGTH(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // reference model: elements of the frame being gathered,
  // the presented buffer, and the expected registered outputs
  logic [7:0]  frame_q [$];
  logic [7:0]  m_x [32];
  bit          m_ready;
  bit          m_launch;
  bit          m_split;
  bit          m_sign;
  int          m_len;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("launch", 32'(bus.launch_o), 32'(m_launch));
    chk("len", 32'(bus.data_length_o), 32'(m_len));
    chk("split", 32'(bus.split_o), 32'(m_split));
    chk("sign", 32'(bus.sign_ctrl_o), 32'(m_sign));
    chk("fcnt", 32'(bus.frame_cnt_o), 32'(m_cnt));
    if (m_launch)
      for (int i = 0; i < 32; i++)
        chk($sformatf("x[%0d]", i), 32'(bus.x_o[i]), 32'(m_x[i]));
  endtask

  task automatic model_clear();
    frame_q.delete();
    for (int i = 0; i < 32; i++) m_x[i] = 8'h00;
    m_launch = 0;
    m_split  = 0;
    m_sign   = 0;
    m_len    = 0;
    m_cnt    = 16'h0;
  endtask

  // one clock: check last cycle's results, drive, predict
  task automatic step(input bit v, input logic [7:0] d,
                      input bit l, input bit sg);
    @(negedge clk);
    check_outputs();
    bus.s_valid_i   = v;
    bus.s_data_i    = d;
    bus.s_last_i    = l;
    bus.sign_ctrl_i = sg;
    #1;
    chk("ready", 32'(bus.s_ready_o), 32'(m_ready));
    m_launch = 0;
    m_split  = 0;
    m_len    = 0;
    if (v && m_ready) begin
      frame_q.push_back(d);
      m_x[frame_q.size() - 1] = d;
      if (frame_q.size() == 1) m_sign = sg;
      if (l || frame_q.size() == 32) begin
        m_launch = 1;
        m_split  = !l;
        m_len    = frame_q.size();
        m_cnt    = m_cnt + 16'd1;
        frame_q.delete();
      end
    end
    m_ready = !m_launch;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.s_valid_i = 0;
    #2 rst = 1'b1;
    #1;
    model_clear();
    chk("rst_ready", 32'(bus.s_ready_o), 32'd0);
    check_outputs();
    for (int i = 0; i < 32; i++)
      chk("rst_x", 32'(bus.x_o[i]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_ready", 32'(bus.s_ready_o), 32'd0);
    m_ready = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'($urandom), 0, 0);
  endtask

  task automatic rand_run(input int cycles, input int lastdiv);
    for (int i = 0; i < cycles; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, lastdiv - 1) == 0,
           1'($urandom));
  endtask

  initial begin
    bus.s_valid_i   = 0;
    bus.s_data_i    = '0;
    bus.s_last_i    = 0;
    bus.sign_ctrl_i = 0;
    model_clear();
    m_ready = 0;
    do_reset();

    // five beats, last on the fifth, valid held through launch
    step(1, 8'd9, 0, 0);
    step(1, 8'd3, 0, 0);
    step(1, 8'd7, 0, 0);
    step(1, 8'd1, 0, 0);
    step(1, 8'd5, 1, 0);
    step(1, 8'd9, 0, 0);
    idle(2);

    // single-beat frame
    step(1, 8'hAA, 1, 0);
    idle(2);

    // 35 beats, last only on the final one
    for (int i = 0; i < 35; i++) begin
      step(1, 8'(i), i == 34, 0);
      if (!m_ready) step(1, 8'(i + 1), i + 1 == 34, 0);
      if (!m_ready) i++;
    end
    idle(2);

    // gapped valid, then valid held across the launch bubble
    step(1, 8'h11, 0, 0);
    step(0, 8'h22, 1, 0);
    step(1, 8'h33, 0, 0);
    step(0, 8'h44, 1, 0);
    step(1, 8'h55, 1, 0);
    step(1, 8'h66, 0, 0);
    step(1, 8'h66, 1, 0);
    idle(2);

    // sign flag only sampled on the first beat
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 0);
    step(1, 8'h03, 0, 0);
    step(1, 8'h04, 1, 0);
    idle(2);

    // reset in the middle of a frame, then a 2-beat frame
    step(1, 8'h10, 0, 0);
    step(1, 8'h20, 0, 0);
    step(1, 8'h30, 0, 0);
    do_reset();
    step(1, 8'h40, 0, 0);
    step(1, 8'h50, 1, 0);
    idle(2);

    // random streams: short frames, then long ones that split
    rand_run(600, 6);
    rand_run(600, 60);
    do_reset();
    rand_run(400, 12);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
